// File: rtl/axi_lite_pkt_master.sv
// AXI-Lite write initiator feeding the packet validator/sorter slave.
// Optional WAIT_B timeout: define AXI_PKT_MASTER_TIMEOUT_EN.
module axi_lite_pkt_master #(
  parameter logic [7:0] DATA_ADDR      = 8'h00,
  parameter logic [7:0] COMMIT_ADDR    = 8'h04,
  parameter int         TIMEOUT_CYCLES = 10,
  parameter int         CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pkt_data,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  output logic [7:0]       aw_addr,
  output logic             aw_valid,
  input  logic             aw_ready,
  output logic [31:0]      w_data,
  output logic             w_valid,
  input  logic             w_ready,
  input  logic             b_response,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             done,
  output logic             resp_ok,
  output logic             timeout,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE, DATA_AW, DATA_W, COMMIT_AW, COMMIT_W, WAIT_B
  } state_t;

  state_t state, state_n;

  logic [31:0]      pkt_q, pkt_q_n;
  logic             pkt_ready_n;
  logic [7:0]       aw_addr_n;
  logic             aw_valid_n;
  logic [31:0]      w_data_n;
  logic             w_valid_n;
  logic             b_ready_n;
  logic             done_n;
  logic             resp_ok_n;
  logic [CNT_W-1:0] ok_cnt_n;
  logic [CNT_W-1:0] err_cnt_n;

`ifdef AXI_PKT_MASTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              timeout_q, timeout_n;

  assign timeout = timeout_q;
`else
  // Feature compiled out: constant 0 for any legal limit.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // State and registered outputs; reset aborts any partial write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pkt_q     <= '0;
      pkt_ready <= 1'b1;
      aw_addr   <= '0;
      aw_valid  <= 1'b0;
      w_data    <= '0;
      w_valid   <= 1'b0;
      b_ready   <= 1'b0;
      done      <= 1'b0;
      resp_ok   <= 1'b0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
`ifdef AXI_PKT_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      pkt_q     <= pkt_q_n;
      pkt_ready <= pkt_ready_n;
      aw_addr   <= aw_addr_n;
      aw_valid  <= aw_valid_n;
      w_data    <= w_data_n;
      w_valid   <= w_valid_n;
      b_ready   <= b_ready_n;
      done      <= done_n;
      resp_ok   <= resp_ok_n;
      ok_cnt    <= ok_cnt_n;
      err_cnt   <= err_cnt_n;
`ifdef AXI_PKT_MASTER_TIMEOUT_EN
      wait_cnt  <= wait_cnt_n;
      timeout_q <= timeout_n;
`endif
    end
  end

  // Next state and next output values; everything holds by default.
  always_comb begin
    state_n     = state;
    pkt_q_n     = pkt_q;
    pkt_ready_n = pkt_ready;
    aw_addr_n   = aw_addr;
    aw_valid_n  = aw_valid;
    w_data_n    = w_data;
    w_valid_n   = w_valid;
    b_ready_n   = b_ready;
    done_n      = 1'b0;
    resp_ok_n   = resp_ok;
    ok_cnt_n    = ok_cnt;
    err_cnt_n   = err_cnt;
`ifdef AXI_PKT_MASTER_TIMEOUT_EN
    wait_cnt_n  = wait_cnt;
    timeout_n   = timeout_q;
`endif
    unique case (state)
      IDLE: begin
        pkt_ready_n = 1'b1;
        if (pkt_valid && pkt_ready) begin
          pkt_q_n     = pkt_data;
          pkt_ready_n = 1'b0;
          aw_addr_n   = DATA_ADDR;
          aw_valid_n  = 1'b1;
          state_n     = DATA_AW;
        end
      end
      DATA_AW: begin
        if (aw_valid && aw_ready) begin
          aw_valid_n = 1'b0;
          w_data_n   = pkt_q;
          w_valid_n  = 1'b1;
          state_n    = DATA_W;
        end
      end
      DATA_W: begin
        if (w_valid && w_ready) begin
          w_valid_n  = 1'b0;
          aw_addr_n  = COMMIT_ADDR;
          aw_valid_n = 1'b1;
          state_n    = COMMIT_AW;
        end
      end
      COMMIT_AW: begin
        if (aw_valid && aw_ready) begin
          aw_valid_n = 1'b0;
          w_data_n   = 32'h0;
          w_valid_n  = 1'b1;
          state_n    = COMMIT_W;
        end
      end
      COMMIT_W: begin
        if (w_valid && w_ready) begin
          w_valid_n  = 1'b0;
          b_ready_n  = 1'b1;
          state_n    = WAIT_B;
`ifdef AXI_PKT_MASTER_TIMEOUT_EN
          wait_cnt_n = '0;
`endif
        end
      end
      WAIT_B: begin
        // A response in the limit cycle still counts as a response.
        if (b_valid && b_ready) begin
          b_ready_n   = 1'b0;
          resp_ok_n   = b_response;
          done_n      = 1'b1;
          pkt_ready_n = 1'b1;
          state_n     = IDLE;
          if (b_response) ok_cnt_n = ok_cnt + CNT_W'(1);
          else            err_cnt_n = err_cnt + CNT_W'(1);
`ifdef AXI_PKT_MASTER_TIMEOUT_EN
          timeout_n   = 1'b0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          b_ready_n   = 1'b0;
          resp_ok_n   = 1'b0;
          timeout_n   = 1'b1;
          done_n      = 1'b1;
          pkt_ready_n = 1'b1;
          err_cnt_n   = err_cnt + CNT_W'(1);
          state_n     = IDLE;
        end else begin
          wait_cnt_n  = wait_cnt + WAIT_W'(1);
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_pkt_master.sv
// Directed self-checking bench for axi_lite_pkt_master.
// Timeout scenario runs only when AXI_PKT_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_pkt_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        b_response;
  logic        b_valid;
  logic        b_ready;
  logic        done;
  logic        resp_ok;
  logic        timeout;
  logic [7:0]  ok_cnt;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0]  aw_log[$];
  logic [31:0] w_log[$];

  axi_lite_pkt_master dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_data   (pkt_data),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .aw_addr    (aw_addr),
    .aw_valid   (aw_valid),
    .aw_ready   (aw_ready),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .b_response (b_response),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .done       (done),
    .resp_ok    (resp_ok),
    .timeout    (timeout),
    .ok_cnt     (ok_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Handshake logger plus hold-while-stalled checker.
  logic        pv_aw = 1'b0;
  logic        pv_w  = 1'b0;
  logic [7:0]  pa;
  logic [31:0] pd;
  always @(posedge clk) begin
    if (!rst) begin
      if (pv_aw) begin
        checks++;
        if (aw_valid !== 1'b1 || aw_addr !== pa) begin
          errors++;
          $display("FAIL aw_hold: valid=%b addr=%h want valid=1 addr=%h",
                   aw_valid, aw_addr, pa);
        end
      end
      if (pv_w) begin
        checks++;
        if (w_valid !== 1'b1 || w_data !== pd) begin
          errors++;
          $display("FAIL w_hold: valid=%b data=%h want valid=1 data=%h",
                   w_valid, w_data, pd);
        end
      end
      if (aw_valid && aw_ready) aw_log.push_back(aw_addr);
      if (w_valid && w_ready) w_log.push_back(w_data);
    end
    pv_aw = !rst && aw_valid && !aw_ready;
    pv_w  = !rst && w_valid && !w_ready;
    pa    = aw_addr;
    pd    = w_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Send one packet starting in IDLE, #1 after an edge.
  // lat = edge index (acceptance edge = 0) after which done is seen.
  task automatic send(input logic [31:0] d, input logic resp,
                      input logic bv, input int aws, input int ws,
                      output int lat);
    int awl;
    int wl;
    awl = aws;
    wl  = ws;
    pkt_data   = d;
    pkt_valid  = 1'b1;
    b_response = resp;
    b_valid    = bv;
    aw_ready   = 1'b1;
    w_ready    = 1'b1;
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (aw_valid && awl > 0) begin
        aw_ready = 1'b0;
        awl--;
      end else aw_ready = 1'b1;
      if (w_valid && wl > 0) begin
        w_ready = 1'b0;
        wl--;
      end else w_ready = 1'b1;
      @(posedge clk); #1;
    end
    aw_ready = 1'b1;
    w_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pkt_data   = '0;
    pkt_valid  = 1'b0;
    aw_ready   = 1'b1;
    w_ready    = 1'b1;
    b_response = 1'b0;
    b_valid    = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({pkt_ready, aw_valid, w_valid, b_ready, done, resp_ok, timeout}
        !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1000000",
               {pkt_ready, aw_valid, w_valid, b_ready, done, resp_ok, timeout});
    end
    checks++;
    if (ok_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: ok=%0d err=%0d want 0 0", ok_cnt, err_cnt);
    end
    checks++;
    if (aw_addr !== 8'h00 || w_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h want 00 0", aw_addr, w_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_accept();
    int lat;
    aw_log.delete();
    w_log.delete();
    send(32'hA5001122, 1'b1, 1'b1, 0, 0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL accept_lat: got %0d want 5", lat);
    end
    checks++;
    if (aw_log.size() != 2 || aw_log[0] !== 8'h00 || aw_log[1] !== 8'h04) begin
      errors++;
      $display("FAIL accept_addr: n=%0d want 2 (00,04)", aw_log.size());
    end
    checks++;
    if (w_log.size() != 2 || w_log[0] !== 32'hA5001122 || w_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL accept_data: n=%0d want 2 (A5001122,0)", w_log.size());
    end
    checks++;
    if ({resp_ok, timeout, pkt_ready} !== 3'b101) begin
      errors++;
      $display("FAIL accept_resp: got %b want 101", {resp_ok, timeout, pkt_ready});
    end
    checks++;
    if (ok_cnt !== 8'd1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL accept_cnt: ok=%0d err=%0d want 1 0", ok_cnt, err_cnt);
    end
    // b_valid stays high while idle and must be ignored
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || b_ready !== 1'b0 || ok_cnt !== 8'd1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL idle_bvalid: done=%b b_ready=%b ok=%0d err=%0d want 0 0 1 0",
               done, b_ready, ok_cnt, err_cnt);
    end
  endtask

  task automatic test_reject();
    int lat;
    send(32'hFF334455, 1'b0, 1'b1, 0, 0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL reject_lat: got %0d want 5", lat);
    end
    checks++;
    if (resp_ok !== 1'b0 || ok_cnt !== 8'd1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL reject: resp_ok=%b ok=%0d err=%0d want 0 1 1",
               resp_ok, ok_cnt, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    aw_log.delete();
    w_log.delete();
    send(32'h12345678, 1'b1, 1'b1, 3, 2, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL bp_lat: got %0d want 10", lat);
    end
    checks++;
    if (aw_log.size() != 2 || aw_log[0] !== 8'h00 || aw_log[1] !== 8'h04 ||
        w_log.size() != 2 || w_log[0] !== 32'h12345678 || w_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL bp_xfers: aw=%0d w=%0d want 2 2 with 00/04 and 12345678/0",
               aw_log.size(), w_log.size());
    end
    checks++;
    if (ok_cnt !== 8'd2 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_cnt: ok=%0d err=%0d want 2 1", ok_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int  idx;
    int  dn;
    int  bad;
    bit  acc;
    idx = 0;
    dn  = 0;
    bad = 0;
    pkt_data   = 32'hA5000000;
    pkt_valid  = 1'b1;
    b_valid    = 1'b1;
    acc        = pkt_ready;
    b_response = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx == 10) pkt_valid = 1'b0;
        else pkt_data = (idx % 2 == 1) ? 32'hFF000000 + idx : 32'hA5000000 + idx;
      end
      if (done) dn++;
      if (pkt_ready !== !(aw_valid | w_valid | b_ready)) bad++;
      acc = pkt_valid && pkt_ready;
      if (acc) b_response = (pkt_data[31:24] == 8'hA5);
      if (idx == 10 && dn == 10) break;
    end
    checks++;
    if (dn !== 10) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses want 10", dn);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_ready: %0d cycles with pkt_ready outside IDLE want 0", bad);
    end
    checks++;
    if (ok_cnt !== 8'd7 || err_cnt !== 8'd6) begin
      errors++;
      $display("FAIL b2b_cnt: ok=%0d err=%0d want 7 6", ok_cnt, err_cnt);
    end
  endtask

`ifdef AXI_PKT_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    send(32'hA5009999, 1'b1, 1'b0, 0, 0, lat);
    checks++;
    if (lat !== 14 || timeout !== 1'b1 || resp_ok !== 1'b0) begin
      errors++;
      $display("FAIL timeout: lat=%0d timeout=%b resp_ok=%b want 14 1 0",
               lat, timeout, resp_ok);
    end
    checks++;
    if (ok_cnt !== 8'd7 || err_cnt !== 8'd7) begin
      errors++;
      $display("FAIL timeout_cnt: ok=%0d err=%0d want 7 7", ok_cnt, err_cnt);
    end
    send(32'hA500AAAA, 1'b1, 1'b1, 0, 0, lat);
    checks++;
    if (lat !== 5 || timeout !== 1'b0 || resp_ok !== 1'b1 || ok_cnt !== 8'd8) begin
      errors++;
      $display("FAIL timeout_next: lat=%0d timeout=%b resp_ok=%b ok=%0d want 5 0 1 8",
               lat, timeout, resp_ok, ok_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    pkt_data   = 32'hC0FFEE01;
    pkt_valid  = 1'b1;
    b_valid    = 1'b1;
    b_response = 1'b1;
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (aw_valid !== 1'b1 || aw_addr !== 8'h04) begin
      errors++;
      $display("FAIL mid_state: aw_valid=%b addr=%h want 1 04", aw_valid, aw_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pkt_ready, aw_valid, w_valid, b_ready, done} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_rst_flags: got %b want 10000",
               {pkt_ready, aw_valid, w_valid, b_ready, done});
    end
    checks++;
    if (ok_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst_cnt: ok=%0d err=%0d want 0 0", ok_cnt, err_cnt);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(32'hA5112233, 1'b1, 1'b1, 0, 0, lat);
    checks++;
    if (lat !== 5 || resp_ok !== 1'b1 || ok_cnt !== 8'd1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_fresh: lat=%0d resp_ok=%b ok=%0d err=%0d want 5 1 1 0",
               lat, resp_ok, ok_cnt, err_cnt);
    end
  endtask

  task automatic test_wrap();
    int lat;
    int bad;
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      send(32'hA5000000 + i, 1'b1, 1'b1, 0, 0, lat);
      if (lat != 5) bad++;
    end
    checks++;
    if (bad !== 0 || ok_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap: bad=%0d ok=%0d err=%0d want 0 0 0", bad, ok_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_reject();
    test_backpressure();
    test_back_to_back();
`ifdef AXI_PKT_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
